// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared N_REQ:1 mux with hold-time limit.
// The owner keeps the grant until done, its request drops, or HOLD_MAX cycles elapse.
module mux_rr_arbiter #(
    parameter int N_REQ    = 16,
    parameter int SEL_W    = 4,
    parameter int HOLD_MAX = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic             timeout
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, win, idx;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             at_limit, normal_rel;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_q + SEL_W'(i);
            if (req[idx]) win = idx;
        end
    end

    assign at_limit   = cnt_q == CNT_W'(HOLD_MAX - 1);
    assign normal_rel = done || !req[sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = OWN;
                sel_d   = win;
                gnt_d   = N_REQ'(1) << win;
                cnt_d   = '0;
            end
        end else if (normal_rel || at_limit) begin
            state_d   = IDLE;
            sel_d     = '0;
            gnt_d     = '0;
            ptr_d     = sel_q + 1'b1;
            timeout_d = !normal_rel;
        end else begin
            cnt_d = (cnt_q == CNT_W'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = state_q == OWN;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios with hand-computed grant, select and timeout values.
module tb_mux_rr_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        gnt_valid;
    logic        timeout;
    int          errors = 0;
    int          checks = 0;

    mux_rr_arbiter #(.N_REQ(16), .SEL_W(4), .HOLD_MAX(64)) dut (
        .clk(clk), .rstn(rstn), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 16'h0) begin errors++; $display("FAIL reset_gnt got %h exp 0000", gnt); end
        checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    endtask

    task automatic test_basic();
        do_reset();
        req = 16'h0001;
        tick();
        checks++; if (gnt !== 16'h0001 || sel !== 4'd0 || gnt_valid !== 1'b1) begin errors++; $display("FAIL basic_grant got gnt=%h sel=%0d v=%b exp 0001 0 1", gnt, sel, gnt_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt !== 16'h0 || gnt_valid !== 1'b0) begin errors++; $display("FAIL basic_release got gnt=%h v=%b exp 0000 0", gnt, gnt_valid); end
        req = 16'h0003;
        tick();
        checks++; if (sel !== 4'd1 || gnt !== 16'h0002) begin errors++; $display("FAIL basic_ptr1 got sel=%0d gnt=%h exp 1 0002", sel, gnt); end
    endtask

    task automatic test_rotate();
        logic [15:0] one;
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            one = 16'h0001 << (k % 16);
            tick();
            checks++; if (sel !== 4'(k % 16) || gnt !== one || gnt_valid !== 1'b1) begin errors++; $display("FAIL rotate_grant%0d got sel=%0d gnt=%h exp %0d %h", k, sel, gnt, k % 16, one); end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++; if (gnt_valid !== 1'b0 || gnt !== 16'h0) begin errors++; $display("FAIL rotate_gap%0d got v=%b gnt=%h exp 0 0000", k, gnt_valid, gnt); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        tick();
        checks++; if (sel !== 4'd15) begin errors++; $display("FAIL wrap_owner got %0d exp 15", sel); end
        req  = 16'h8001;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++; if (sel !== 4'd0 || gnt !== 16'h0001) begin errors++; $display("FAIL wrap_next got sel=%0d gnt=%h exp 0 0001", sel, gnt); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req = 16'h0010;
        tick();
        cnt = gnt_valid ? 1 : 0;
        for (int i = 0; i < 100 && gnt_valid; i++) begin
            tick();
            if (gnt_valid) cnt++;
        end
        checks++; if (cnt !== 64) begin errors++; $display("FAIL hold_cycles got %0d exp 64", cnt); end
        checks++; if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse got to=%b v=%b exp 1 0", timeout, gnt_valid); end
        tick();
        checks++; if (timeout !== 1'b0 || gnt_valid !== 1'b1 || sel !== 4'd4) begin errors++; $display("FAIL timeout_regrant got to=%b v=%b sel=%0d exp 0 1 4", timeout, gnt_valid, sel); end
    endtask

    task automatic test_simultaneous();
        for (int m = 0; m < 2; m++) begin
            do_reset();
            req = 16'h0010;
            tick();
            for (int i = 0; i < 63; i++) tick();
            checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL simul%0d_held got %b exp 1", m, gnt_valid); end
            if (m == 0) done = 1'b1;
            else req = 16'h0000;
            tick();
            done = 1'b0;
            checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL simul%0d_release got v=%b to=%b exp 0 0", m, gnt_valid, timeout); end
        end
    endtask

    task automatic test_reset_own();
        do_reset();
        req = 16'h0080;
        tick();
        checks++; if (sel !== 4'd7) begin errors++; $display("FAIL rstown_owner got %0d exp 7", sel); end
        rstn = 1'b0;
        req  = 16'h0081;
        tick();
        checks++; if (gnt !== 16'h0 || sel !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rstown_clear got gnt=%h sel=%0d v=%b to=%b exp 0000 0 0 0", gnt, sel, gnt_valid, timeout); end
        rstn = 1'b1;
        tick();
        checks++; if (sel !== 4'd0 || gnt !== 16'h0001) begin errors++; $display("FAIL rstown_first got sel=%0d gnt=%h exp 0 0001", sel, gnt); end
    endtask

    task automatic test_ignore();
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL idle_done got v=%b exp 0", gnt_valid); end
        req = 16'h0004;
        tick();
        checks++; if (sel !== 4'd2 || gnt !== 16'h0004) begin errors++; $display("FAIL ignore_grant got sel=%0d gnt=%h exp 2 0004", sel, gnt); end
        req = 16'h000E;
        tick();
        checks++; if (sel !== 4'd2 || gnt !== 16'h0004 || gnt_valid !== 1'b1) begin errors++; $display("FAIL ignore_others got sel=%0d gnt=%h v=%b exp 2 0004 1", sel, gnt, gnt_valid); end
        req = 16'h0008;
        tick();
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reqdrop_release got v=%b to=%b exp 0 0", gnt_valid, timeout); end
        tick();
        checks++; if (sel !== 4'd3 || gnt !== 16'h0008) begin errors++; $display("FAIL reqdrop_next got sel=%0d gnt=%h exp 3 0008", sel, gnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotate();
        test_wrap();
        test_timeout();
        test_simultaneous();
        test_reset_own();
        test_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 16, number of requesters sharing the 16x1 mux.
REQ-002 The block SHALL have parameter SEL_W, default 4, select width; N_REQ == 2**SEL_W.
REQ-003 The block SHALL have parameter HOLD_MAX, default 64, maximum cycles one owner may hold the grant.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-006 The block SHALL have port req, input, N_REQ, per-requester request level; bit i is requester i.
REQ-007 The block SHALL have port done, input, 1, owner finished; sampled only in OWN.
REQ-008 The block SHALL have port gnt, output, N_REQ, registered one-hot grant; all zero when no owner.
REQ-009 The block SHALL have port sel, output, SEL_W, registered mux select equal to the owner index; 0 when no owner.
REQ-010 The block SHALL have port gnt_valid, output, 1, high while an owner holds the mux.
REQ-011 The block SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and OWN.
REQ-013 IDLE with req != 0: next edge -> OWN, load the owner and set gnt, sel, gnt_valid, clear hold counter; grant latency is 1 cycle.
REQ-014 IDLE with req == 0: remain IDLE, outputs zero.
REQ-015 Winner SHALL be the first set req bit in search order ptr, ptr+1, ..., ptr+N_REQ-1, all modulo N_REQ.
REQ-016 In OWN, gnt, sel and owner SHALL stay constant; changes on req bits other than the owner's are ignored.
REQ-017 In OWN, hold counter SHALL increment by 1 per cycle, saturating at HOLD_MAX.
REQ-018 In OWN, release SHALL occur at the edge where done==1, req[owner]==0, or counter==HOLD_MAX-1.
REQ-019 On release: next state IDLE; gnt, sel, gnt_valid cleared; ptr <= (owner+1) mod N_REQ; exactly one zero-grant gap cycle precedes any new grant.
REQ-020 ptr wrap-around: owner N_REQ-1 SHALL set ptr to 0.
REQ-021 timeout SHALL pulse high for one cycle, coincident with the gap cycle, only when release is caused solely by the HOLD_MAX limit.
REQ-022 Simultaneous events: done or req[owner] drop coinciding with the HOLD_MAX limit SHALL count as normal release; timeout stays 0.
REQ-023 done asserted in IDLE SHALL be ignored.
REQ-024 gnt SHALL never have more than one bit set, and sel SHALL always equal the index of the set gnt bit.

Reset
REQ-025 rstn==0 at a rising edge SHALL force IDLE, ptr=0, counter=0, gnt=0, sel=0, gnt_valid=0, timeout=0.
REQ-026 Reset asserted in OWN SHALL drop the grant at that edge with no timeout pulse; the first grant after reset SHALL search from index 0.

Verification
REQ-027 After reset, req=16'h0001 -> one cycle later gnt=16'h0001, sel=0, gnt_valid=1; done=1 for one cycle -> next cycle gnt=0, ptr=1.
REQ-028 req=16'hFFFF, done pulsed one cycle after each grant -> grants rotate sel=0,1,...,15,0 with one gap cycle between grants.
REQ-029 Owner sel=15, release -> ptr=0; with req=16'h8001 the next grant is sel=0.
REQ-030 HOLD_MAX=64, req=16'h0010 held, done=0 -> gnt_valid high for exactly 64 cycles, then timeout=1 for one cycle, then re-grant sel=4.
REQ-031 done=1 on the HOLD_MAX limit cycle -> release occurs with timeout=0.
REQ-032 rstn=0 while OWN with sel=7 -> next cycle all outputs 0; req=16'h0081 after reset -> sel=0 granted.
